// File: rtl/iomem_bridge_master_if.sv
// Byte-stream and iomem bus signals of the iomem bridge master.
// master: the bridge (consumes rx bytes, produces tx bytes, initiates iomem requests)
// slave : the environment (byte source/sink and iomem responder)
interface iomem_bridge_master_if;
   logic        rx_valid;
   logic [7:0]  rx_data;
   logic        rx_ready;
   logic        tx_valid;
   logic [7:0]  tx_data;
   logic        tx_ready;
   logic        iomem_valid;
   logic        iomem_ready;
   logic [3:0]  iomem_wstrb;
   logic [31:0] iomem_addr;
   logic [31:0] iomem_wdata;
   logic [31:0] iomem_rdata;

   modport master (
      input  rx_valid, rx_data,
      output rx_ready,
      output tx_valid, tx_data,
      input  tx_ready,
      output iomem_valid, iomem_wstrb, iomem_addr, iomem_wdata,
      input  iomem_ready, iomem_rdata
   );

   modport slave (
      output rx_valid, rx_data,
      input  rx_ready,
      input  tx_valid, tx_data,
      output tx_ready,
      input  iomem_valid, iomem_wstrb, iomem_addr, iomem_wdata,
      output iomem_ready, iomem_rdata
   );
endinterface

// File: rtl/iomem_bridge_master.sv
// iomem_bridge_master: byte-stream to iomem bus initiator.
// Packet: cmd ('W' 0x57 / 'R' 0x52), 4 address bytes LSB first, then 4 data bytes
// LSB first for writes. One iomem transfer is issued per packet; the reply is
// 'K' for a write, the 4 read-data bytes LSB first for a read, or 'T' on timeout.
// Optional feature macro: IOMEM_BRIDGE_TIMEOUT_EN (bounds how long a request may
// wait for iomem_ready; TIMEOUT_CYCLES sets the bound).
module iomem_bridge_master #(
   parameter int unsigned TIMEOUT_CYCLES = 255
) (
   input  logic                         clk,
   input  logic                         resetn,
   iomem_bridge_master_if.master        bus,
   output logic                         busy
);

   typedef enum logic [2:0] {IDLE, ADDR, DATA, BUS, RESP} state_t;
   typedef enum logic [1:0] {RESP_ACK, RESP_RDATA, RESP_TMO} resp_t;

   localparam logic [7:0] CMD_WRITE = 8'h57;
   localparam logic [7:0] CMD_READ  = 8'h52;
   localparam logic [7:0] BYTE_ACK  = 8'h4B;
   localparam logic [7:0] BYTE_TMO  = 8'h54;

   state_t      state, state_nx;
   logic [1:0]  cnt, cnt_nx;
   logic        is_write;
   resp_t       resp_kind;
   logic [31:0] addr_q;
   logic [31:0] wdata_q;
   logic [31:0] rdata_q;

   logic        rx_fire;
   logic        tx_fire;
   logic        cmd_ok;
   logic        bus_done;
   logic        timeout_hit;
   logic        last_byte;

   assign cmd_ok    = (bus.rx_data == CMD_WRITE) || (bus.rx_data == CMD_READ);
   assign rx_fire   = bus.rx_valid && bus.rx_ready;
   assign tx_fire   = bus.tx_valid && bus.tx_ready;
   assign bus_done  = (state == BUS) && bus.iomem_ready;
   assign last_byte = (resp_kind != RESP_RDATA) || (cnt == 2'd3);

`ifdef IOMEM_BRIDGE_TIMEOUT_EN
   localparam int unsigned TO_W = ($clog2(TIMEOUT_CYCLES + 1) > 8) ? $clog2(TIMEOUT_CYCLES + 1) : 8;
   localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);

   logic [TO_W-1:0] to_cnt;

   // Stall counter: zero outside BUS, counts cycles the request waits for ready
   always_ff @(posedge clk) begin
      if (!resetn || (state != BUS))
         to_cnt <= '0;
      else if (!bus.iomem_ready)
         to_cnt <= to_cnt + 1'b1;
   end

   // The limit is reached on the cycle the count would become TIMEOUT_CYCLES,
   // so the request is high for exactly TIMEOUT_CYCLES cycles; ready wins a tie.
   assign timeout_hit = (state == BUS) && !bus.iomem_ready && (to_cnt == TO_LAST);
`else
   // No timeout path: BUS waits for iomem_ready indefinitely. The parameter is
   // referenced only so both builds expose an identical parameter list.
   assign timeout_hit = 1'b0 && (TIMEOUT_CYCLES == 0);
`endif

   // State and byte-counter register
   always_ff @(posedge clk) begin
      if (!resetn) begin
         state <= IDLE;
         cnt   <= '0;
      end else begin
         state <= state_nx;
         cnt   <= cnt_nx;
      end
   end

   // Next-state and byte-counter logic; counter restarts on every state entry
   always_comb begin
      state_nx = state;
      cnt_nx   = cnt;
      case (state)
         IDLE: begin
            if (rx_fire && cmd_ok) begin
               state_nx = ADDR;
               cnt_nx   = '0;
            end
         end
         ADDR: begin
            if (rx_fire) begin
               cnt_nx = cnt + 2'd1;
               if (cnt == 2'd3) begin
                  state_nx = is_write ? DATA : BUS;
                  cnt_nx   = '0;
               end
            end
         end
         DATA: begin
            if (rx_fire) begin
               cnt_nx = cnt + 2'd1;
               if (cnt == 2'd3) begin
                  state_nx = BUS;
                  cnt_nx   = '0;
               end
            end
         end
         BUS: begin
            if (bus_done || timeout_hit) begin
               state_nx = RESP;
               cnt_nx   = '0;
            end
         end
         RESP: begin
            if (tx_fire) begin
               if (last_byte) begin
                  state_nx = IDLE;
                  cnt_nx   = '0;
               end else begin
                  cnt_nx = cnt + 2'd1;
               end
            end
         end
         default: begin
            state_nx = IDLE;
            cnt_nx   = '0;
         end
      endcase
   end

   // Packet fields, captured read data and reply kind
   always_ff @(posedge clk) begin
      if (!resetn) begin
         is_write  <= 1'b0;
         resp_kind <= RESP_ACK;
         addr_q    <= '0;
         wdata_q   <= '0;
         rdata_q   <= '0;
      end else begin
         if ((state == IDLE) && rx_fire && cmd_ok) begin
            is_write <= (bus.rx_data == CMD_WRITE);
            if (bus.rx_data == CMD_READ)
               wdata_q <= '0;
         end
         if ((state == ADDR) && rx_fire)
            addr_q[{cnt, 3'b000} +: 8] <= bus.rx_data;
         if ((state == DATA) && rx_fire)
            wdata_q[{cnt, 3'b000} +: 8] <= bus.rx_data;
         if (bus_done) begin
            rdata_q   <= bus.iomem_rdata;
            resp_kind <= is_write ? RESP_ACK : RESP_RDATA;
         end else if (timeout_hit) begin
            resp_kind <= RESP_TMO;
         end
      end
   end

   // Outputs decoded from the registered state so reset clears them on the next edge
   always_comb begin
      bus.rx_ready    = (state == IDLE) || (state == ADDR) || (state == DATA);
      bus.iomem_valid = (state == BUS);
      bus.iomem_wstrb = ((state == BUS) && is_write) ? 4'hF : 4'h0;
      bus.iomem_addr  = addr_q;
      bus.iomem_wdata = wdata_q;
      bus.tx_valid    = (state == RESP);
      bus.tx_data     = '0;
      if (state == RESP) begin
         case (resp_kind)
            RESP_ACK:   bus.tx_data = BYTE_ACK;
            RESP_TMO:   bus.tx_data = BYTE_TMO;
            RESP_RDATA: bus.tx_data = rdata_q[{cnt, 3'b000} +: 8];
            default:    bus.tx_data = '0;
         endcase
      end
      busy = (state != IDLE);
   end

endmodule

// File: tb/tb_iomem_bridge_master.sv
// Self-checking bench for iomem_bridge_master: directed vector table, garbage,
// backpressure, timeout / no-timeout and mid-BUS reset sequences, then random
// packets checked against a packet-level reference model.
module tb_iomem_bridge_master;

   logic clk = 1'b0;
   logic resetn = 1'b0;
   logic busy;

   iomem_bridge_master_if bus();

   iomem_bridge_master #(.TIMEOUT_CYCLES(16)) dut (
      .clk    (clk),
      .resetn (resetn),
      .bus    (bus),
      .busy   (busy)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   // responder control / observation
   int          resp_delay = 0;
   logic [31:0] resp_rdata = '0;
   bit          resp_never = 1'b0;
   bit          ready_noise = 1'b0;
   int          req_count = 0;
   int          valid_cycles = 0;
   int          stab_err = 0;
   logic [31:0] cap_addr = '0;
   logic [31:0] cap_wdata = '0;
   logic [3:0]  cap_wstrb = '0;
   bit          r_seen = 1'b0;
   int          r_waited = 0;

   int          rx_gap_max = 0;
   logic [7:0]  got_q[$];

   typedef struct {
      bit          wr;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [31:0] rdata;
      int          delay;
      int          stall;
      logic [31:0] exp_bytes;
      int          exp_n;
      logic [3:0]  exp_wstrb;
   } vec_t;

   vec_t vecs[4];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Reference model: reply bytes and strobe follow from the packet alone
   function automatic void model(input bit wr, input bit tmo, input logic [31:0] rdata,
                                 output logic [31:0] eb, output int n, output logic [3:0] ws);
      ws = wr ? 4'hF : 4'h0;
      if (tmo) begin
         eb = 32'h54; n = 1;
      end else if (wr) begin
         eb = 32'h4B; n = 1;
      end else begin
         eb = rdata; n = 4;
      end
   endfunction

   // iomem responder: records each request, checks stability, answers after resp_delay
   initial begin
      bus.iomem_ready = 1'b0;
      bus.iomem_rdata = '0;
      forever begin
         @(posedge clk); #1;
         bus.iomem_ready = 1'b0;
         if (bus.iomem_valid) begin
            if (!r_seen) begin
               r_seen = 1'b1;
               r_waited = 0;
               req_count++;
               valid_cycles = 0;
               cap_addr = bus.iomem_addr;
               cap_wdata = bus.iomem_wdata;
               cap_wstrb = bus.iomem_wstrb;
            end else if (bus.iomem_addr !== cap_addr || bus.iomem_wdata !== cap_wdata ||
                         bus.iomem_wstrb !== cap_wstrb) begin
               stab_err++;
            end
            valid_cycles++;
            if (!resp_never && r_waited == resp_delay) begin
               bus.iomem_ready = 1'b1;
               bus.iomem_rdata = resp_rdata;
            end
            r_waited++;
         end else begin
            r_seen = 1'b0;
            if (ready_noise) begin
               bus.iomem_ready = 1'($urandom_range(0, 1));
               bus.iomem_rdata = $urandom;
            end
         end
      end
   end

   task automatic send_byte(input logic [7:0] b);
      int n;
      bit acc;
      int gap;
      gap = (rx_gap_max > 0) ? $urandom_range(0, rx_gap_max) : 0;
      for (int g = 0; g < gap; g++) begin
         @(posedge clk); #1;
      end
      n = 0;
      acc = 1'b0;
      bus.rx_valid = 1'b1;
      bus.rx_data = b;
      do begin
         acc = bus.rx_ready;
         @(posedge clk); #1;
         n++;
      end while (!acc && n < 100);
      bus.rx_valid = 1'b0;
      check("rx_accept", 32'(acc), 32'd1);
   endtask

   task automatic collect(input int stall, input int n_exp, output int rx_bad, output int hold_bad);
      int stall_left;
      int cycles;
      bit have_held;
      logic [7:0] held;
      got_q.delete();
      stall_left = stall;
      cycles = 0;
      have_held = 1'b0;
      held = '0;
      rx_bad = 0;
      hold_bad = 0;
      while (got_q.size() < n_exp && cycles < 300) begin
         if ((bus.iomem_valid || bus.tx_valid) && bus.rx_ready) rx_bad++;
         if (bus.tx_valid) begin
            if (stall_left > 0) begin
               bus.tx_ready = 1'b0;
               if (have_held && bus.tx_data !== held) hold_bad++;
               held = bus.tx_data;
               have_held = 1'b1;
               stall_left--;
            end else begin
               if (have_held && bus.tx_data !== held) hold_bad++;
               have_held = 1'b0;
               bus.tx_ready = 1'b1;
               got_q.push_back(bus.tx_data);
            end
         end else begin
            bus.tx_ready = 1'b0;
         end
         @(posedge clk); #1;
         cycles++;
      end
      bus.tx_ready = 1'b0;
   endtask

   task automatic run_txn(input string tag, input bit wr, input logic [31:0] addr,
                          input logic [31:0] wdata, input logic [31:0] rdata,
                          input int delay, input int stall, input bit tmo,
                          input logic [31:0] exp_bytes, input int exp_n, input logic [3:0] exp_wstrb);
      int rq0, st0, rx_bad, hold_bad, n;
      rq0 = req_count;
      st0 = stab_err;
      resp_delay = delay;
      resp_rdata = rdata;
      resp_never = tmo;
      send_byte(wr ? 8'h57 : 8'h52);
      for (int i = 0; i < 4; i++) send_byte(addr[8*i +: 8]);
      if (wr) for (int i = 0; i < 4; i++) send_byte(wdata[8*i +: 8]);
      collect(stall, exp_n, rx_bad, hold_bad);
      resp_never = 1'b0;
      n = got_q.size();
      check({tag, " resp_len"}, 32'(n), 32'(exp_n));
      for (int i = 0; i < exp_n && i < n; i++)
         check($sformatf("%s resp_byte%0d", tag, i), 32'(got_q[i]), 32'(exp_bytes[8*i +: 8]));
      check({tag, " req_count"}, 32'(req_count - rq0), 32'd1);
      check({tag, " addr"}, cap_addr, addr);
      check({tag, " wstrb"}, 32'(cap_wstrb), 32'(exp_wstrb));
      if (wr) check({tag, " wdata"}, cap_wdata, wdata);
      check({tag, " bus_stable"}, 32'(stab_err - st0), 32'd0);
      check({tag, " rx_blocked"}, 32'(rx_bad), 32'd0);
      check({tag, " tx_hold"}, 32'(hold_bad), 32'd0);
      check({tag, " idle_tx_valid"}, 32'(bus.tx_valid), 32'd0);
      check({tag, " idle_busy"}, 32'(busy), 32'd0);
      check({tag, " idle_rx_ready"}, 32'(bus.rx_ready), 32'd1);
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, " rx_ready"}, 32'(bus.rx_ready), 32'd1);
      check({tag, " tx_valid"}, 32'(bus.tx_valid), 32'd0);
      check({tag, " tx_data"}, 32'(bus.tx_data), 32'd0);
      check({tag, " iomem_valid"}, 32'(bus.iomem_valid), 32'd0);
      check({tag, " iomem_wstrb"}, 32'(bus.iomem_wstrb), 32'd0);
      check({tag, " iomem_addr"}, bus.iomem_addr, 32'd0);
      check({tag, " iomem_wdata"}, bus.iomem_wdata, 32'd0);
      check({tag, " busy"}, 32'(busy), 32'd0);
   endtask

   // Watchdog: the run must never hang
   initial begin
      #3000000;
      $display("FAIL watchdog: simulation time limit reached");
      $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
      $fatal(1, "watchdog");
   end

   initial begin
      logic [31:0] eb;
      int en;
      logic [3:0] ews;
      int hold_cycles;

      vecs[0] = '{1'b1, 32'h0300_0000, 32'h0000_0005, 32'h0,          2, 0, 32'h4B,         1, 4'hF};
      vecs[1] = '{1'b0, 32'h0300_0000, 32'h0,          32'hDEAD_BEEF, 0, 0, 32'hDEAD_BEEF, 4, 4'h0};
      vecs[2] = '{1'b0, 32'h0300_0004, 32'h0,          32'h1234_5678, 3, 5, 32'h1234_5678, 4, 4'h0};
      vecs[3] = '{1'b1, 32'hFFFF_FFFC, 32'hA5A5_5A5A, 32'h0,          0, 0, 32'h4B,         1, 4'hF};

      bus.rx_valid = 1'b0;
      bus.rx_data = '0;
      bus.tx_ready = 1'b0;
      resetn = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check_reset_outputs("reset");
      resetn = 1'b1;

      // directed vectors, including the 5-cycle tx backpressure case
      foreach (vecs[i])
         run_txn($sformatf("vec%0d", i), vecs[i].wr, vecs[i].addr, vecs[i].wdata, vecs[i].rdata,
                 vecs[i].delay, vecs[i].stall, 1'b0, vecs[i].exp_bytes, vecs[i].exp_n, vecs[i].exp_wstrb);

      // garbage bytes in IDLE are dropped, then a normal read
      send_byte(8'h00);
      check("garbage0 busy", 32'(busy), 32'd0);
      send_byte(8'hFF);
      check("garbage1 busy", 32'(busy), 32'd0);
      run_txn("after_garbage", 1'b0, 32'h0300_0000, 32'h0, 32'hCAFE_F00D, 1, 0, 1'b0,
              32'hCAFE_F00D, 4, 4'h0);

`ifdef IOMEM_BRIDGE_TIMEOUT_EN
      model(1'b0, 1'b1, 32'h0, eb, en, ews);
      run_txn("timeout", 1'b0, 32'h0300_0010, 32'h0, 32'h0, 0, 0, 1'b1, eb, en, ews);
      check("timeout valid_cycles", 32'(valid_cycles), 32'd16);
      hold_cycles = 5;
`else
      hold_cycles = 40;
`endif

      // request with no responder: held (no timeout) or still pending, then reset mid-BUS
      resp_never = 1'b1;
      send_byte(8'h52);
      for (int i = 0; i < 4; i++) send_byte(8'h33);
      repeat (hold_cycles) @(posedge clk);
      #1;
      check("pending valid", 32'(bus.iomem_valid), 32'd1);
      check("pending busy", 32'(busy), 32'd1);
      check("pending tx_valid", 32'(bus.tx_valid), 32'd0);
      resetn = 1'b0;
      @(posedge clk); #1;
      check_reset_outputs("midbus_reset");
      resetn = 1'b1;
      resp_never = 1'b0;
      run_txn("post_reset", 1'b1, 32'h0300_0008, 32'h0000_00FF, 32'h0, 1, 0, 1'b0,
              32'h4B, 1, 4'hF);

      // random packets against the reference model, with ready noise and rx gaps
      ready_noise = 1'b1;
      rx_gap_max = 2;
      for (int t = 0; t < 30; t++) begin
         bit wr;
         logic [31:0] a, d, r;
         logic [7:0] g;
         wr = 1'($urandom_range(0, 1));
         a = $urandom;
         d = $urandom;
         r = $urandom;
         if ($urandom_range(0, 3) == 0) begin
            g = 8'($urandom_range(0, 255));
            if (g == 8'h57 || g == 8'h52) g = 8'h00;
            send_byte(g);
            check("rand garbage busy", 32'(busy), 32'd0);
         end
         model(wr, 1'b0, r, eb, en, ews);
         run_txn($sformatf("rand%0d", t), wr, a, d, r, $urandom_range(0, 10),
                 $urandom_range(0, 3), 1'b0, eb, en, ews);
      end
      ready_noise = 1'b0;

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
